sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
- Downstream consumer of the message-schedule stage: takes the expanded 64-word W vector plus the current chaining hash, runs the 64 SHA-256 compression rounds at one round per clock, and produces the updated 256-bit intermediate hash.
- Sits between the W-schedule generator and the top-level block sequencer. The sequencer feeds `hash_out` back as `hash_in` for multi-block messages.

Parameters:
- W_LENGTH, 64, number of schedule words and rounds; only 64 is supported; the round counter is $clog2(W_LENGTH)+1 bits wide.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  start request, sampled only in IDLE
- w_vector_complete  input  1  W vector valid qualifier; start is accepted only when enable && w_vector_complete
- w_vector  input  2048  schedule words; W[i] = w_vector[32*i+31 : 32*i]
- hash_in  input  256  chaining value; H0 = [255:224] ... H7 = [31:0]
- busy  output  1  high while a block is in progress
- hash_valid  output  1  one-cycle pulse: hash_out updated
- hash_out  output  256  result, same word order as hash_in; held until the next completion

Behaviour:
- States: IDLE, ROUND, FINAL.
- Internal storage:
  - 2048-bit W buffer;
  - 256-bit H buffer;
  - working registers a..h;
  - round counter t;
  - K[0..63] constant ROM, per FIPS 180-4, combinational case on t.
- Reset (synchronous): state=IDLE, t=0, busy=0, hash_valid=0, hash_out=0, a..h=0, buffers=0. Reset overrides everything, including mid-operation; any in-flight block is discarded with no hash_valid.
- IDLE:
  - On an edge where enable && w_vector_complete (edge E): latch w_vector into the W buffer, hash_in into the H buffer and into a..h; set t=0, busy=1, state=ROUND.
  - Otherwise hold. Inputs may change freely after E.
- ROUND (edges E+1 .. E+64): each edge applies one round with W[t] and K[t]:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
  - All additions mod 2^32; rotates are 32-bit right-rotates:
    - Σ0 = ROTR2^ROTR13^ROTR22
    - Σ1 = ROTR6^ROTR11^ROTR25
    - Ch = (e&f)^(~e&g)
    - Maj = (a&b)^(a&c)^(b&c)
  - t increments each round. On the edge applying t=63, state=FINAL.
- FINAL (edge E+65): hash_out[Hi] = H buffer Hi + working reg (mod 2^32 per word); hash_valid=1, busy=0, state=IDLE.
- hash_valid is high exactly one cycle (E+65..E+66) and is cleared on the next edge.
- Latency: accept edge to hash_valid = 65 clocks. Throughput: one block per 66 clocks max. A new start may be accepted on the edge immediately after FINAL, i.e. while hash_valid is high.
- enable/w_vector_complete while busy are ignored (no queuing, no error).
- enable high with w_vector_complete low: no start.
- hash_out is stable between completions. It is not cleared when a new block starts.

Test Plan:
- Reset, then idle 10 cycles -> busy=0, hash_valid=0, hash_out=0.
- "abc" block: hash_in = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); W from a bench model with W0=61626380, W15=00000018, W1..W14=0; one-cycle start -> hash_valid exactly 65 clocks later with hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: W0=80000000, other message words 0, hash_in = IV -> hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdef...nopq" (56 bytes): second start issued on the hash_valid cycle with hash_in = previous hash_out -> final 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; check no idle gap is required.
- Start pulses at rounds 5 and 40 of an active block, and enable=1 with w_vector_complete=0 in IDLE -> no restart, result unchanged from the single-block run, no hash_valid from the ignored request.
- Assert reset at round 30 of a block -> busy=0 and hash_out=0 on the next edge, no hash_valid; a fresh "abc" run afterwards gives the correct digest.

Source files
------------

// File: rtl/sha256_compress_if.sv
// rtl/sha256_compress_if.sv - handshake and data bundle between the block sequencer and the SHA-256 compression core
//   master : sequencer side (drives enable, w_vector_complete, w_vector, hash_in; observes busy, hash_valid, hash_out)
//   slave  : compression core side
interface sha256_compress_if #(
    parameter int W_LENGTH = 64
);
    logic                    enable;
    logic                    w_vector_complete;
    logic [32*W_LENGTH-1:0]  w_vector;
    logic [255:0]            hash_in;
    logic                    busy;
    logic                    hash_valid;
    logic [255:0]            hash_out;

    modport master (
        output enable, w_vector_complete, w_vector, hash_in,
        input  busy, hash_valid, hash_out
    );

    modport slave (
        input  enable, w_vector_complete, w_vector, hash_in,
        output busy, hash_valid, hash_out
    );
endinterface

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 compression: 64 rounds at one round per clock over a pre-expanded W vector
//   clock : rising-edge clock
//   reset : synchronous active-high reset, discards any in-flight block
//   bus   : slave side of sha256_compress_if
//           enable && w_vector_complete starts a block in IDLE; busy covers the whole block;
//           hash_valid pulses one cycle when hash_out (chaining + working regs) is updated
module sha256_compress #(
    parameter int W_LENGTH = 64
) (
    input  logic              clock,
    input  logic              reset,
    sha256_compress_if.slave  bus
);
    localparam int TW = $clog2(W_LENGTH) + 1;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t                  state, state_next;
    logic [32*W_LENGTH-1:0]  w_buf;
    logic [255:0]            h_buf;
    logic [255:0]            hash_out;
    logic                    hash_valid;
    logic [31:0]             a, b, c, d, e, f, g, h;
    logic [TW-1:0]           t;
    logic                    start;

    assign start = bus.enable && bus.w_vector_complete;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] i);
        logic [31:0] k;
        case (i)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7;
            default: k = 32'hc67178f2;
        endcase
        return k;
    endfunction

    // Round function for the current t
    logic [31:0] w_t, s0, s1, ch, maj, t1, t2;
    always_comb begin
        w_t = w_buf[{t[5:0], 5'd0} +: 32];
        s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch  = (e & f) ^ (~e & g);
        t1  = h + s1 + ch + k_rom(t[5:0]) + w_t;
        s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t2  = s0 + maj;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ROUND;
            ROUND:   if (t == TW'(W_LENGTH - 1)) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy       = (state != IDLE);
        bus.hash_valid = hash_valid;
        bus.hash_out   = hash_out;
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            w_buf      <= '0;
            h_buf      <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            t          <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
        end else begin
            hash_valid <= (state == FINAL);
            case (state)
                IDLE: begin
                    if (start) begin
                        w_buf <= bus.w_vector;
                        h_buf <= bus.hash_in;
                        {a, b, c, d, e, f, g, h} <= bus.hash_in;
                        t     <= '0;
                    end
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    t <= t + 1'b1;
                end
                FINAL: begin
                    hash_out <= {h_buf[255:224] + a, h_buf[223:192] + b,
                                 h_buf[191:160] + c, h_buf[159:128] + d,
                                 h_buf[127:96]  + e, h_buf[95:64]   + f,
                                 h_buf[63:32]   + g, h_buf[31:0]    + h};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - self-checking bench for sha256_compress against a FIPS 180-4 reference model
module tb_sha256_compress;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sha256_compress_if bus ();

    sha256_compress dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [31:0] kk [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule from a 512-bit block (word 0 in the top bits)
    function automatic logic [2047:0] expand(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] v;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7]  + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 64; i++) v[32*i +: 32] = w[i];
        return v;
    endfunction

    function automatic logic [255:0] ref_compress(input logic [2047:0] wv, input logic [255:0] hin);
        logic [31:0] r [8];
        logic [31:0] hh [8];
        logic [31:0] x1, x2;
        logic [255:0] o;
        for (int i = 0; i < 8; i++) begin
            hh[i] = hin[255 - 32*i -: 32];
            r[i]  = hh[i];
        end
        for (int i = 0; i < 64; i++) begin
            x1 = r[7] + (rotr(r[4], 6) ^ rotr(r[4], 11) ^ rotr(r[4], 25))
               + ((r[4] & r[5]) ^ (~r[4] & r[6])) + kk[i] + wv[32*i +: 32];
            x2 = (rotr(r[0], 2) ^ rotr(r[0], 13) ^ rotr(r[0], 22))
               + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
            for (int j = 7; j > 0; j--) r[j] = r[j-1];
            r[4] = r[4] + x1;
            r[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) o[255 - 32*i -: 32] = hh[i] + r[i];
        return o;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents a start, then waits for hash_valid (bounded).
    // Returns at the negedge where hash_valid is seen so a back-to-back start can follow.
    // inject=1 pulses start requests a few rounds into the block and at round 40.
    task automatic run_block(input logic [2047:0] wv, input logic [255:0] hin,
                             input bit inject, output int lat);
        logic [255:0] prev;
        prev = bus.hash_out;
        bus.w_vector = wv;
        bus.hash_in  = hin;
        bus.enable   = 1'b1;
        bus.w_vector_complete = 1'b1;
        lat = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                bus.enable = 1'b0;
                check("busy_after_start", {255'd0, bus.busy}, 256'd1);
                check("hash_out_held_on_start", bus.hash_out, prev);
            end
            if (inject && (cyc == 6 || cyc == 41)) begin
                bus.enable = 1'b1;
                bus.w_vector = {64{$urandom()}};
                bus.hash_in  = {8{$urandom()}};
            end else if (inject && (cyc == 7 || cyc == 42)) begin
                bus.enable = 1'b0;
            end
            if (bus.hash_valid) begin
                lat = cyc - 1;
                break;
            end
        end
        bus.enable = 1'b0;
        check("latency", 256'(lat), 256'd65);
        check("busy_low_at_valid", {255'd0, bus.busy}, 256'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [2047:0] w_abc, w_empty, w_b1, w_b2, wr;
        logic [255:0]  h_mid, hr, snap;

        bus.enable = 1'b0;
        bus.w_vector_complete = 1'b0;
        bus.w_vector = '0;
        bus.hash_in  = '0;

        w_abc   = expand({32'h61626380, 448'd0, 32'h00000018});
        w_empty = expand({32'h80000000, 480'd0});
        w_b1    = expand({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
        w_b2    = expand({480'd0, 32'h000001c0});

        // Reset and idle
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("reset_busy", {255'd0, bus.busy}, 256'd0);
        check("reset_hash_valid", {255'd0, bus.hash_valid}, 256'd0);
        check("reset_hash_out", bus.hash_out, 256'd0);

        // "abc"
        run_block(w_abc, IV, 1'b0, lat);
        check("abc_digest", bus.hash_out, D_ABC);
        check("abc_model", bus.hash_out, ref_compress(w_abc, IV));
        @(negedge clock);
        check("valid_one_cycle", {255'd0, bus.hash_valid}, 256'd0);
        repeat (5) @(negedge clock);
        check("hash_out_stable", bus.hash_out, D_ABC);

        // enable without w_vector_complete must not start
        bus.enable = 1'b1;
        bus.w_vector_complete = 1'b0;
        repeat (5) @(negedge clock);
        check("no_start_busy", {255'd0, bus.busy}, 256'd0);
        bus.enable = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(negedge clock);
            if (bus.hash_valid) pulses++;
        end
        check("no_start_valid", 256'(pulses), 256'd0);

        // Empty message
        run_block(w_empty, IV, 1'b0, lat);
        check("empty_digest", bus.hash_out, D_EMPTY);

        // Two blocks, second start on the hash_valid cycle
        run_block(w_b1, IV, 1'b0, lat);
        h_mid = bus.hash_out;
        check("two_mid_model", h_mid, ref_compress(w_b1, IV));
        run_block(w_b2, h_mid, 1'b0, lat);
        check("two_digest", bus.hash_out, D_TWO);

        // Start requests while busy are ignored
        repeat (3) @(negedge clock);
        run_block(w_abc, IV, 1'b1, lat);
        check("ignored_start_digest", bus.hash_out, D_ABC);
        pulses = 0;
        repeat (70) begin
            @(negedge clock);
            if (bus.hash_valid) pulses++;
        end
        check("ignored_start_no_valid", 256'(pulses), 256'd0);
        bus.w_vector_complete = 1'b1;

        // Reset during round 30
        bus.w_vector = w_empty;
        bus.hash_in  = IV;
        bus.enable   = 1'b1;
        @(negedge clock);
        bus.enable = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {255'd0, bus.busy}, 256'd0);
        check("midreset_hash_out", bus.hash_out, 256'd0);
        check("midreset_valid", {255'd0, bus.hash_valid}, 256'd0);
        reset = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clock);
            if (bus.hash_valid) pulses++;
        end
        check("midreset_no_valid", 256'(pulses), 256'd0);
        run_block(w_abc, IV, 1'b0, lat);
        check("after_reset_abc", bus.hash_out, D_ABC);

        // Random W vectors and chaining values
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 64; i++) wr[32*i +: 32] = $urandom();
            for (int i = 0; i < 8; i++)  hr[32*i +: 32] = $urandom();
            @(negedge clock);
            run_block(wr, hr, n[0], lat);
            snap = bus.hash_out;
            check("random_model", snap, ref_compress(wr, hr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
